vga_sprite_scanner: RTL and testbench

- Pixel-scan master and compositor that sits on the far side of the sprite-layer drawers.
- Generates the raster coordinates the sprite blocks consume (X, Y) and waits out their fixed pipeline latency.
- Accepts their per-pixel valid/RGB result and composites it over a background colour.
- Drives the VGA DAC pins with sync and blank signals aligned to the delayed pixel data.
- Also emits a once-per-frame pulse so sprite-position logic can update only during vertical blanking.

---
 rtl/vga_sprite_scanner.sv | 149 ++++++++++++++
 tb/tb_vga_sprite_scanner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_scanner.sv
// Raster scan master and sprite compositor: drives X/Y to the sprite layer and
// composites its delayed reply over a background. Optional colour key: `define SPRITE_COLORKEY_EN.
module vga_sprite_scanner #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          SPRITE_LAT   = 2,
  parameter logic [23:0] COLORKEY_RGB = 24'hFF00FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] oVGA_X,
  output logic [8:0] oVGA_Y,
  output logic       oCoord_valid,
  input  logic       iSprite_val,
  input  logic [7:0] iSprite_R,
  input  logic [7:0] iSprite_G,
  input  logic [7:0] iSprite_B,
  input  logic [7:0] iBg_R,
  input  logic [7:0] iBg_G,
  input  logic [7:0] iBg_B,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oFrame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef SPRITE_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
  } ctl_t;

  localparam ctl_t CTL_IDLE = 3'b011;

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        fs_q, fs_d;
  logic        act_c;
  ctl_t        ctl_d;
  ctl_t        pipe_q [SPRITE_LAT+1];
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, vs_q, blank_q;
  logic        key_hit, spr_sel;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  always_comb begin
    act_c = (h_q < H_ACT) && (v_q < V_ACT);
    ctl_d = CTL_IDLE;
    if (enable) begin
      ctl_d.act  = act_c;
      ctl_d.hs_n = !((h_q >= HS_BEG) && (h_q <= HS_END));
      ctl_d.vs_n = !((v_q >= VS_BEG) && (v_q <= VS_END));
    end
    fs_d = enable && (h_q == 10'd0) && (v_q == V_ACT);
  end

  // The colour key only ever masks the valid bit, so it is purely combinational
  // on the sampled sprite word and leaves the latency alone.
  assign key_hit = KEY_EN && ({iSprite_R, iSprite_G, iSprite_B} == COLORKEY_RGB);
  assign spr_sel = iSprite_val && !key_hit;

  always_comb begin
    rgb_d = '0;
    if (pipe_q[SPRITE_LAT].act)
      rgb_d = spr_sel ? {iSprite_R, iSprite_G, iSprite_B} : {iBg_R, iBg_G, iBg_B};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      for (int i = 0; i <= SPRITE_LAT; i++) pipe_q[i] <= CTL_IDLE;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      x_q       <= (enable && act_c) ? h_q : '0;
      y_q       <= (enable && act_c) ? v_q[8:0] : '0;
      fs_q      <= fs_d;
      pipe_q[0] <= ctl_d;
      // stage 0 is the coordinate stage; stages 1..SPRITE_LAT wait out the sprite layer
      for (int i = 1; i <= SPRITE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      rgb_q     <= rgb_d;
      hs_q      <= pipe_q[SPRITE_LAT].hs_n;
      vs_q      <= pipe_q[SPRITE_LAT].vs_n;
      blank_q   <= pipe_q[SPRITE_LAT].act;
    end
  end

  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oCoord_valid = pipe_q[0].act;
  assign oFrame_start = fs_q;
  assign oVGA_R       = rgb_q[23:16];
  assign oVGA_G       = rgb_q[15:8];
  assign oVGA_B       = rgb_q[7:0];
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blank_q;

endmodule

// File: tb/tb_vga_sprite_scanner.sv
// Self-checking bench for vga_sprite_scanner; timing is scaled down so that two
// whole frames fit comfortably in the simulation budget.
module tb_vga_sprite_scanner;

  localparam int HA = 128, HFP = 8, HSW = 16, HBP = 8;
  localparam int VA = 60, VFP = 3, VSW = 2, VBP = 5;
  localparam int L = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [47:0] IDLE_V = {10'd0, 9'd0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef SPRITE_COLORKEY_EN
  localparam bit KEY = 1'b1;
`else
  localparam bit KEY = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic       iSprite_val = 1'b0;
  logic [7:0] iSprite_R = '0, iSprite_G = '0, iSprite_B = '0;
  logic [7:0] iBg_R = '0, iBg_G = '0, iBg_B = '0;
  logic [9:0] oVGA_X;
  logic [8:0] oVGA_Y;
  logic       oCoord_valid, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFrame_start;
  logic [7:0] oVGA_R, oVGA_G, oVGA_B;
  logic [47:0] got;

  assign got = {oVGA_X, oVGA_Y, oCoord_valid, oVGA_R, oVGA_G, oVGA_B,
                oVGA_HS, oVGA_VS, oVGA_BLANK_N, oFrame_start};

  vga_sprite_scanner #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SPRITE_LAT(L), .COLORKEY_RGB(24'hFF00FF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .oVGA_X(oVGA_X), .oVGA_Y(oVGA_Y), .oCoord_valid(oCoord_valid),
    .iSprite_val(iSprite_val), .iSprite_R(iSprite_R), .iSprite_G(iSprite_G), .iSprite_B(iSprite_B),
    .iBg_R(iBg_R), .iBg_G(iBg_G), .iBg_B(iBg_B),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oFrame_start(oFrame_start)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cnt = 0;       // pixels scanned since the last restart
  int hist[$];       // scan index shown on the coordinate outputs, newest first; -1 = idle
  int mode = 0;
  logic [47:0] exp_v;

  function automatic int hof(int idx); return idx % HT; endfunction
  function automatic int vof(int idx); return (idx / HT) % VT; endfunction
  function automatic bit is_act(int idx);
    if (idx < 0) return 1'b0;
    return (hof(idx) < HA) && (vof(idx) < VA);
  endfunction

  task automatic model_reset();
    cnt = 0;
    hist.delete();
    for (int i = 0; i < L + 2; i++) hist.push_back(-1);
    exp_v = IDLE_V;
  endtask

  // Sprite layer + background source, answering for the coordinate issued L cycles ago.
  task automatic drive_inputs();
    int idx;
    idx = hist[L];
    {iSprite_R, iSprite_G, iSprite_B} = 24'($urandom);
    {iBg_R, iBg_G, iBg_B} = 24'($urandom);
    iSprite_val = 1'($urandom);
    case (mode)
      1: begin
        {iBg_R, iBg_G, iBg_B} = 24'h010203;
        iSprite_val = is_act(idx) && hof(idx) == 100 && vof(idx) == 50;
        if (iSprite_val) {iSprite_R, iSprite_G, iSprite_B} = 24'h0A141E;
      end
      2: begin
        iSprite_val = 1'b1;
        {iSprite_R, iSprite_G, iSprite_B} = 24'hFFFFFF;
      end
      3: begin
        iSprite_val = 1'b1;
        if ($urandom_range(0, 1) == 1) {iSprite_R, iSprite_G, iSprite_B} = 24'hFF00FF;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    logic sv, en, fs, a2, hs, vs;
    logic [23:0] sp, bg, rgb;
    logic [9:0] x;
    logic [8:0] y;
    int i0, i2;
    sv = iSprite_val; sp = {iSprite_R, iSprite_G, iSprite_B};
    bg = {iBg_R, iBg_G, iBg_B}; en = enable;
    @(posedge clk); #1;
    if (!reset) begin
      model_reset();
    end else begin
      hist.push_front(en ? cnt : -1);
      void'(hist.pop_back());
      cnt = en ? cnt + 1 : 0;
      i0 = hist[0];
      i2 = hist[L+1];
      x  = is_act(i0) ? 10'(hof(i0)) : 10'd0;
      y  = is_act(i0) ? 9'(vof(i0)) : 9'd0;
      fs = (i0 >= 0) && hof(i0) == 0 && vof(i0) == VA;
      a2 = is_act(i2);
      hs = !((i2 >= 0) && hof(i2) >= HA + HFP && hof(i2) < HA + HFP + HSW);
      vs = !((i2 >= 0) && vof(i2) >= VA + VFP && vof(i2) < VA + VFP + VSW);
      if (!a2) rgb = 24'd0;
      else if (sv && !(KEY && sp == 24'hFF00FF)) rgb = sp;
      else rgb = bg;
      exp_v = {x, y, is_act(i0), rgb, hs, vs, a2, fs};
    end
    drive_inputs();
  endtask

  task automatic test_reset();
    int n;
    enable = 1'b1; mode = 0;
    model_reset(); drive_inputs();
    #2 reset = 1'b0;
    repeat (3) begin
      step(); checks++;
      if (got !== IDLE_V) begin failures++; $display("FAIL reset_hold got=%h exp=%h", got, IDLE_V); end
    end
    reset = 1'b1;
    step(); checks++;
    if ({oVGA_X, oVGA_Y, oCoord_valid} !== {10'd0, 9'd0, 1'b1}) begin
      failures++; $display("FAIL first_coord got=%h/%h/%b exp=0/0/1", oVGA_X, oVGA_Y, oCoord_valid);
    end
    n = 0;
    while (!oVGA_BLANK_N && n < 10) begin step(); n++; end
    checks++;
    if (n != L + 1) begin failures++; $display("FAIL blank_rise got=%0d exp=%0d", n, L + 1); end
  endtask

  task automatic test_line();
    int ls0 = -1, ls1 = -1, hs_fall = -1, hs_len = -1;
    logic prev_hs;
    mode = 0; prev_hs = oVGA_HS;
    for (int c = 1; c <= 3 * HT; c++) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL line_px got=%h exp=%h", got, exp_v); end
      if (oCoord_valid && oVGA_X == 10'd0) begin
        if (ls0 < 0) ls0 = c; else if (ls1 < 0) ls1 = c;
      end
      if (ls0 >= 0 && prev_hs && !oVGA_HS && hs_fall < 0) hs_fall = c;
      if (hs_fall >= 0 && !prev_hs && oVGA_HS && hs_len < 0) hs_len = c - hs_fall;
      prev_hs = oVGA_HS;
    end
    checks++;
    if (hs_len != HSW) begin failures++; $display("FAIL hs_width got=%0d exp=%0d", hs_len, HSW); end
    checks++;
    if (hs_fall - ls0 != HA + HFP + L + 1) begin
      failures++; $display("FAIL hs_start got=%0d exp=%0d", hs_fall - ls0, HA + HFP + L + 1);
    end
    checks++;
    if (ls1 - ls0 != HT) begin failures++; $display("FAIL line_period got=%0d exp=%0d", ls1 - ls0, HT); end
  endtask

  task automatic test_sprite_pixel();
    int hits = 0, hitidx = -1, p;
    int target = 50 * HT + 100;
    mode = 1;
    for (int c = 0; c < FRAME + HT; c++) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL sprite_px got=%h exp=%h", got, exp_v); end
      p = (hist[L+1] >= 0) ? hist[L+1] % FRAME : -1;
      if (oVGA_BLANK_N && {oVGA_R, oVGA_G, oVGA_B} == 24'h0A141E) begin hits++; hitidx = p; end
      if (p == target - 1 || p == target + 1) begin
        checks++;
        if ({oVGA_R, oVGA_G, oVGA_B, oVGA_BLANK_N} !== {24'h010203, 1'b1}) begin
          failures++; $display("FAIL sprite_neigh got=%h exp=0102031", {oVGA_R, oVGA_G, oVGA_B, oVGA_BLANK_N});
        end
      end
      if (p == target + 2) break;
    end
    checks++;
    if (hits != 1) begin failures++; $display("FAIL sprite_hits got=%0d exp=1", hits); end
    checks++;
    if (hitidx != target) begin failures++; $display("FAIL sprite_pos got=%0d exp=%0d", hitidx, target); end
  endtask

  task automatic test_white();
    int fs_n = 0, fs1 = -1, fs2 = -1, vsf = -1, vsl = -1;
    logic prev_vs;
    mode = 2; prev_vs = oVGA_VS;
    for (int c = 0; c < 2 * FRAME + HT && fs_n < 2; c++) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL white_px got=%h exp=%h", got, exp_v); end
      if (!oVGA_BLANK_N) begin
        checks++;
        if ({oVGA_R, oVGA_G, oVGA_B} !== 24'd0) begin
          failures++; $display("FAIL blank_rgb got=%h exp=000000", {oVGA_R, oVGA_G, oVGA_B});
        end
      end
      if (oFrame_start) begin fs_n++; if (fs_n == 1) fs1 = c; else fs2 = c; end
      if (fs1 >= 0 && prev_vs && !oVGA_VS && vsf < 0) vsf = c;
      if (vsf >= 0 && !prev_vs && oVGA_VS && vsl < 0) vsl = c - vsf;
      prev_vs = oVGA_VS;
    end
    checks++;
    if (fs_n != 2 || fs2 - fs1 != FRAME) begin
      failures++; $display("FAIL frame_period got=%0d exp=%0d (pulses=%0d)", fs2 - fs1, FRAME, fs_n);
    end
    checks++;
    if (vsf - fs1 != VFP * HT + L + 1) begin
      failures++; $display("FAIL vs_start got=%0d exp=%0d", vsf - fs1, VFP * HT + L + 1);
    end
    checks++;
    if (vsl != VSW * HT) begin failures++; $display("FAIL vs_width got=%0d exp=%0d", vsl, VSW * HT); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    mode = 0;
    for (int c = 0; c < FRAME && !found; c++) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL pre_reset got=%h exp=%h", got, exp_v); end
      if (oCoord_valid && oVGA_X == 10'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reach_x100 got=0 exp=1"); end
    reset = 1'b0; #1;
    checks++;
    if (got !== IDLE_V) begin failures++; $display("FAIL reset_async got=%h exp=%h", got, IDLE_V); end
    model_reset();
    repeat (2) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_mid got=%h exp=%h", got, exp_v); end
    end
    reset = 1'b1;
    for (int c = 0; c < L + 8; c++) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL restart_px got=%h exp=%h", got, exp_v); end
      if (c == 0) begin
        checks++;
        if ({oVGA_X, oVGA_Y, oCoord_valid} !== {10'd0, 9'd0, 1'b1}) begin
          failures++; $display("FAIL restart_coord got=%h/%h/%b exp=0/0/1", oVGA_X, oVGA_Y, oCoord_valid);
        end
      end
    end
  endtask

  task automatic test_enable();
    mode = 0;
    repeat (20) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL pre_en got=%h exp=%h", got, exp_v); end
    end
    enable = 1'b0;
    repeat (5) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL en_low got=%h exp=%h", got, exp_v); end
    end
    enable = 1'b1;
    step(); checks++;
    if ({oVGA_X, oVGA_Y, oCoord_valid} !== {10'd0, 9'd0, 1'b1}) begin
      failures++; $display("FAIL en_restart got=%h/%h/%b exp=0/0/1", oVGA_X, oVGA_Y, oCoord_valid);
    end
    repeat (L + 6) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL en_resume got=%h exp=%h", got, exp_v); end
    end
  endtask

  task automatic test_colorkey();
    mode = 3;
    repeat (2 * HT) begin
      step(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL key_px got=%h exp=%h", got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_sprite_pixel();
    test_white();
    test_reset_mid();
    test_enable();
    test_colorkey();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
